// File: rtl/fp_multiplier.sv
// fp_multiplier: pipelined IEEE-754 single-precision multiplier.
// One operand pair per cycle, no backpressure. An operand pair sampled with
// in_valid at clock edge N is presented with out_valid at edge N+3, in issue order.
// Subnormal inputs are flushed to signed zero, and no subnormal results are produced.
//
// Pipeline registers:
//   s1 (edge N)   : unpack/classify, sign, biased exponent sum
//   s2 (edge N+1) : 24x24 mantissa product
//   s3 (edge N+2) : normalize + round-to-nearest-even
//   out (edge N+3): special-case selection and packing
//
// Ports:
//   clk          in   clock, all state updates on rising edge
//   rst          in   synchronous active-high reset
//   in_valid     in   a_fpn/b_fpn valid this cycle
//   a_fpn, b_fpn in   operands, IEEE-754 single
//   out_valid    out  out and flags valid this cycle
//   out          out  rounded product (holds its value while out_valid=0)
//   flag_ovf     out  result overflowed to infinity
//   flag_unf     out  result underflowed to zero
//   flag_inv     out  invalid operation (NaN input or 0*inf)
//
// Optional build macro FP_MUL_STICKY_FLAGS_EN adds:
//   flag_clr     in   clears the sticky flags (a flag arriving in the same cycle wins)
//   sticky_flags out  accumulated {inv,unf,ovf}
module fp_multiplier #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [EXP_W+MAN_W:0]   a_fpn,
  input  logic [EXP_W+MAN_W:0]   b_fpn,
`ifdef FP_MUL_STICKY_FLAGS_EN
  input  logic                   flag_clr,
  output logic [2:0]             sticky_flags,
`endif
  output logic                   out_valid,
  output logic [EXP_W+MAN_W:0]   out,
  output logic                   flag_ovf,
  output logic                   flag_unf,
  output logic                   flag_inv
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int XW = EXP_W + 2;        // signed exponent width with headroom
  localparam int SW = MAN_W + 1;        // significand incl. hidden bit
  localparam int PW = 2 * SW;           // product width
  localparam int BIAS_I = (32'sd1 <<< (EXP_W - 1)) - 32'sd1;
  localparam int EMAX_I = (32'sd1 <<< EXP_W) - 32'sd1;
  localparam logic signed [XW-1:0] BIAS     = XW'(BIAS_I);
  localparam logic signed [XW-1:0] EXP_MAX  = XW'(EMAX_I);
  localparam logic signed [XW-1:0] EXP_ZERO = '0;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // ---------------- stage 1: unpack / classify ----------------
  logic [EXP_W-1:0] ea_s, eb_s;
  logic [MAN_W-1:0] ma_s, mb_s;
  logic a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
  logic signed [XW-1:0] exp_sum_s;

  assign ea_s = a_fpn[W-2:MAN_W];
  assign eb_s = b_fpn[W-2:MAN_W];
  assign ma_s = a_fpn[MAN_W-1:0];
  assign mb_s = b_fpn[MAN_W-1:0];
  // exponent field 0 covers both true zero and subnormals (flushed)
  assign a_zero_s = (ea_s == '0);
  assign b_zero_s = (eb_s == '0);
  assign a_nan_s  = (&ea_s) & (|ma_s);
  assign b_nan_s  = (&eb_s) & (|mb_s);
  assign a_inf_s  = (&ea_s) & ~(|ma_s);
  assign b_inf_s  = (&eb_s) & ~(|mb_s);
  assign exp_sum_s = $signed({2'b00, ea_s}) + $signed({2'b00, eb_s}) - BIAS;

  logic                 v1_r, sign1_r, inv1_r, inf1_r, zero1_r;
  logic signed [XW-1:0] exp1_r;
  logic [SW-1:0]        man_a1_r, man_b1_r;

  // stage 1 register: classification and significands with hidden bit
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r     <= 1'b0;
      sign1_r  <= 1'b0;
      inv1_r   <= 1'b0;
      inf1_r   <= 1'b0;
      zero1_r  <= 1'b0;
      exp1_r   <= '0;
      man_a1_r <= '0;
      man_b1_r <= '0;
    end else begin
      v1_r     <= in_valid;
      sign1_r  <= a_fpn[W-1] ^ b_fpn[W-1];
      inv1_r   <= a_nan_s | b_nan_s | (a_inf_s & b_zero_s) | (a_zero_s & b_inf_s);
      inf1_r   <= a_inf_s | b_inf_s;
      zero1_r  <= a_zero_s | b_zero_s;
      exp1_r   <= exp_sum_s;
      man_a1_r <= a_zero_s ? '0 : {1'b1, ma_s};
      man_b1_r <= b_zero_s ? '0 : {1'b1, mb_s};
    end
  end

  // ---------------- stage 2: mantissa product ----------------
  logic                 v2_r, sign2_r, inv2_r, inf2_r, zero2_r;
  logic signed [XW-1:0] exp2_r;
  logic [PW-1:0]        prod2_r;

  // stage 2 register: full-width significand product
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_r    <= 1'b0;
      sign2_r <= 1'b0;
      inv2_r  <= 1'b0;
      inf2_r  <= 1'b0;
      zero2_r <= 1'b0;
      exp2_r  <= '0;
      prod2_r <= '0;
    end else begin
      v2_r    <= v1_r;
      sign2_r <= sign1_r;
      inv2_r  <= inv1_r;
      inf2_r  <= inf1_r;
      zero2_r <= zero1_r;
      exp2_r  <= exp1_r;
      prod2_r <= PW'(man_a1_r) * PW'(man_b1_r);
    end
  end

  // ---------------- stage 3: normalize / round ----------------
  logic                 hi_s;
  logic [MAN_W-1:0]     man_s;
  logic                 guard_s, round_s, sticky_s, rnd_up_s;
  logic [MAN_W:0]       man_rnd_s;
  logic signed [XW-1:0] exp_fin_s;

  // product of two normals lies in [1,4): bit PW-1 set means one extra right shift
  assign hi_s      = prod2_r[PW-1];
  assign man_s     = hi_s ? prod2_r[PW-2 -: MAN_W] : prod2_r[PW-3 -: MAN_W];
  assign guard_s   = hi_s ? prod2_r[MAN_W]         : prod2_r[MAN_W-1];
  assign round_s   = hi_s ? prod2_r[MAN_W-1]       : prod2_r[MAN_W-2];
  assign sticky_s  = hi_s ? (|prod2_r[MAN_W-2:0])  : (|prod2_r[MAN_W-3:0]);
  assign rnd_up_s  = guard_s & (round_s | sticky_s | man_s[0]);
  assign man_rnd_s = {1'b0, man_s} + {{MAN_W{1'b0}}, rnd_up_s};
  // a rounding carry leaves the stored fraction at zero; only the exponent moves
  assign exp_fin_s = exp2_r + $signed({{(XW-1){1'b0}}, hi_s})
                            + $signed({{(XW-1){1'b0}}, man_rnd_s[MAN_W]});

  logic                 v3_r, sign3_r, inv3_r, inf3_r, zero3_r;
  logic signed [XW-1:0] exp3_r;
  logic [MAN_W-1:0]     man3_r;

  // stage 3 register: rounded fraction and final exponent
  always_ff @(posedge clk) begin
    if (rst) begin
      v3_r    <= 1'b0;
      sign3_r <= 1'b0;
      inv3_r  <= 1'b0;
      inf3_r  <= 1'b0;
      zero3_r <= 1'b0;
      exp3_r  <= '0;
      man3_r  <= '0;
    end else begin
      v3_r    <= v2_r;
      sign3_r <= sign2_r;
      inv3_r  <= inv2_r;
      inf3_r  <= inf2_r;
      zero3_r <= zero2_r;
      exp3_r  <= exp_fin_s;
      man3_r  <= man_rnd_s[MAN_W-1:0];
    end
  end

  // ---------------- pack with special-case priority ----------------
  logic [W-1:0] res_s;
  logic         ovf_s, unf_s, inv_s;

  // select the result and the single flag for this operation
  always_comb begin
    res_s = '0;
    ovf_s = 1'b0;
    unf_s = 1'b0;
    inv_s = 1'b0;
    if (inv3_r) begin
      res_s = QNAN;
      inv_s = 1'b1;
    end else if (inf3_r) begin
      res_s = {sign3_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (zero3_r) begin
      res_s = {sign3_r, {(W-1){1'b0}}};
    end else if (exp3_r >= EXP_MAX) begin
      res_s = {sign3_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_s = 1'b1;
    end else if (exp3_r <= EXP_ZERO) begin
      res_s = {sign3_r, {(W-1){1'b0}}};
      unf_s = 1'b1;
    end else begin
      res_s = {sign3_r, exp3_r[EXP_W-1:0], man3_r};
    end
  end

  logic         out_valid_r, ovf_r, unf_r, inv_r;
  logic [W-1:0] out_r;

  // output register: result and flags update only with a valid result
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_r       <= '0;
      ovf_r       <= 1'b0;
      unf_r       <= 1'b0;
      inv_r       <= 1'b0;
    end else begin
      out_valid_r <= v3_r;
      if (v3_r) begin
        out_r <= res_s;
        ovf_r <= ovf_s;
        unf_r <= unf_s;
        inv_r <= inv_s;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out       = out_r;
  assign flag_ovf  = ovf_r;
  assign flag_unf  = unf_r;
  assign flag_inv  = inv_r;

`ifdef FP_MUL_STICKY_FLAGS_EN
  logic [2:0] sticky_r;

  // sticky accumulation; a new flag overrides a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_r <= 3'b000;
    end else begin
      sticky_r <= (flag_clr ? 3'b000 : sticky_r)
                | ({inv_r, unf_r, ovf_r} & {3{out_valid_r}});
    end
  end

  assign sticky_flags = sticky_r;
`endif

endmodule

// File: tb/tb_fp_multiplier.sv
module tb_fp_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] a_fpn, b_fpn;
  logic        out_valid;
  logic [31:0] out;
  logic        flag_ovf, flag_unf, flag_inv;
`ifdef FP_MUL_STICKY_FLAGS_EN
  logic        flag_clr;
  logic [2:0]  sticky_flags;
`endif

  fp_multiplier dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a_fpn(a_fpn), .b_fpn(b_fpn),
`ifdef FP_MUL_STICKY_FLAGS_EN
    .flag_clr(flag_clr), .sticky_flags(sticky_flags),
`endif
    .out_valid(out_valid), .out(out),
    .flag_ovf(flag_ovf), .flag_unf(flag_unf), .flag_inv(flag_inv)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        ovf, unf, inv;
    int          due;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_bad = 0;

  // Reference: exact integer product of the significands, rounded to nearest
  // even by integer division/remainder, then the special-case rules.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ovf,
                                output logic unf, output logic inv);
    int     ea, eb, sh, e;
    logic   sgn, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    longint pa, pb, p, unit, keep, rem;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    sgn = a[31] ^ b[31];
    a_nan = (ea == 255) && (a[22:0] != 23'd0);
    b_nan = (eb == 255) && (b[22:0] != 23'd0);
    a_inf = (ea == 255) && (a[22:0] == 23'd0);
    b_inf = (eb == 255) && (b[22:0] == 23'd0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    r = 32'd0; ovf = 1'b0; unf = 1'b0; inv = 1'b0;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      r = 32'h7FC00000;
      inv = 1'b1;
    end else if (a_inf || b_inf) begin
      r = {sgn, 31'h7F800000};
    end else if (a_zero || b_zero) begin
      r = {sgn, 31'd0};
    end else begin
      pa = longint'(a[22:0]) + 64'sd8388608;
      pb = longint'(b[22:0]) + 64'sd8388608;
      p = pa * pb;
      sh = (p >= 64'sd140737488355328) ? 24 : 23;   // 2^47
      unit = 64'sd1 <<< sh;
      keep = p / unit;
      rem  = p % unit;
      if ((rem > unit / 2) || ((rem == unit / 2) && (keep % 2 == 1))) keep = keep + 1;
      e = ea + eb - 150 + sh;
      if (keep == 64'sd16777216) begin
        keep = 64'sd8388608;
        e = e + 1;
      end
      if (e >= 255) begin
        r = {sgn, 31'h7F800000};
        ovf = 1'b1;
      end else if (e <= 0) begin
        r = {sgn, 31'd0};
        unf = 1'b1;
      end else begin
        r = {sgn, e[7:0], keep[22:0]};
      end
    end
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] m;
    int sel;
    sel = $urandom_range(0, 15);
    m = $urandom;
    case (sel)
      0: return {m[31], 31'd0};
      1: return {m[31], 8'd0, m[22:1], 1'b1};
      2: return {m[31], 8'hFF, 23'd0};
      3: return {m[31], 8'hFF, m[22:1], 1'b1};
      4, 5, 6, 7: begin
        logic [7:0] e;
        e = 8'($urandom_range(100, 154));
        return {m[31], e, m[22:0]};
      end
      default: begin
        logic [7:0] e;
        e = 8'($urandom_range(1, 254));
        return {m[31], e, m[22:0]};
      end
    endcase
  endfunction

  // Monitor: pop the oldest expectation whenever a result is presented.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (q.size() > 0 && q[0].due < cyc) begin
        n_bad++;
        $display("FAIL latency: result due at cycle %0d not presented (now %0d)", q[0].due, cyc);
        void'(q.pop_front());
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL spurious: out_valid=1 out=%h at cycle %0d, required no output", out, cyc);
        end else begin
          e = q.pop_front();
          n_vec++;
          if (out !== e.res) begin
            n_bad++;
            $display("FAIL result: out=%h, required %h (cycle %0d)", out, e.res, cyc);
          end
          if ({flag_ovf, flag_unf, flag_inv} !== {e.ovf, e.unf, e.inv}) begin
            n_bad++;
            $display("FAIL flags: {ovf,unf,inv}=%b, required %b (out %h)",
                     {flag_ovf, flag_unf, flag_inv}, {e.ovf, e.unf, e.inv}, e.res);
          end
          if (cyc != e.due) begin
            n_bad++;
            $display("FAIL timing: presented at cycle %0d, required %0d", cyc, e.due);
          end
        end
      end
    end
  end

  task automatic chk_idle(input string nm);
    n_vec++;
    if (out_valid !== 1'b0 || out !== 32'd0 || {flag_ovf, flag_unf, flag_inv} !== 3'b000) begin
      n_bad++;
      $display("FAIL %s: out_valid=%b out=%h flags=%b, required 0/00000000/000",
               nm, out_valid, out, {flag_ovf, flag_unf, flag_inv});
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    in_valid = 1'b1;
    a_fpn = a;
    b_fpn = b;
  endtask

  // sampled at the next edge (cyc+1); the result appears three edges after that
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    drive(a, b);
    model(a, b, e.res, e.ovf, e.unf, e.inv);
    e.due = cyc + 4;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      n++;
    end
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d results outstanding, required 0", q.size());
      q.delete();
    end
  endtask

  logic [31:0] dir_a [0:10];
  logic [31:0] dir_b [0:10];

  initial begin
    dir_a = '{32'h41A00000, 32'h41900000, 32'h40200000, 32'h3FC00000, 32'h7F800000,
              32'h7FC00001, 32'h80000000, 32'h7F7FFFFF, 32'h00800000, 32'h3F800001, 32'h3FB504F3};
    dir_b = '{32'h40000000, 32'h40400000, 32'hC0800000, 32'h3FC00000, 32'h00000000,
              32'h3F800000, 32'h40A00000, 32'h40000000, 32'h3F000000, 32'h3F800001, 32'h3FB504F3};

    rst = 1'b1;
    in_valid = 1'b1;
    a_fpn = 32'h41A00000;
    b_fpn = 32'h40000000;
`ifdef FP_MUL_STICKY_FLAGS_EN
    flag_clr = 1'b0;
`endif
    // reset held for two edges with in_valid asserted
    repeat (2) begin
      @(posedge clk); #1;
      chk_idle("reset");
    end
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk_idle("post_reset");
    end

    // directed vectors back-to-back, then again with bubbles
    for (int i = 0; i < 11; i++) issue(dir_a[i], dir_b[i]);
    idle(2);
    for (int i = 0; i < 11; i++) begin
      issue(dir_a[i], dir_b[i]);
      idle(i % 3);
    end
    drain();

    // randomized operands with random gaps
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1 + $urandom_range(0, 1));
      issue(rand_fp(), rand_fp());
    end
    drain();

    // reset while three operations are in flight: none may emerge
    drive(32'h41A00000, 32'h40000000);
    drive(32'h7F7FFFFF, 32'h40000000);
    drive(32'h7F800000, 32'h00000000);
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk_idle("midflight_reset");
    rst = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      chk_idle("midflight_after");
    end

    // recovery after reset: single overflow case
    issue(32'h7F7FFFFF, 32'h40000000);
    drain();
`ifdef FP_MUL_STICKY_FLAGS_EN
    @(posedge clk); #1;
    n_vec++;
    if (sticky_flags !== 3'b001) begin
      n_bad++;
      $display("FAIL sticky_set: sticky_flags=%b, required 001", sticky_flags);
    end
    flag_clr = 1'b1;
    @(posedge clk); #1;
    flag_clr = 1'b0;
    n_vec++;
    if (sticky_flags !== 3'b000) begin
      n_bad++;
      $display("FAIL sticky_clr: sticky_flags=%b, required 000", sticky_flags);
    end
`endif
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
